// File: rtl/mac_header_parser.sv
`default_nettype none
// ============================================================================
// Module      : mac_header_parser
// Description : Captures DA/SA of each frame, looks up the egress port,
//               learns the source port and presents a forwarding decision.
// Revision    : 1.0
// ============================================================================
module mac_header_parser #(
  parameter int pADRESS = 2,
  parameter int pHASH   = 14
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [7:0]         i_data,
  input  logic               i_sof,
  input  logic               i_eof,
  input  logic [pADRESS-1:0] i_src_port,
  input  logic [pADRESS-1:0] i_table_port,
  output logic               o_write_enable,
  output logic [pADRESS-1:0] o_port_num,
  output logic [pHASH-1:0]   o_MAC_SA,
  output logic [pHASH-1:0]   o_MAC_DA,
  output logic               o_fwd_valid,
  input  logic               i_fwd_ready,
  output logic [pADRESS-1:0] o_fwd_port,
  output logic               o_fwd_flood,
  output logic [7:0]         o_runt_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    LOOKUP  = 3'd2,
    CAPTURE = 3'd3,
    LEARN   = 3'd4,
    RESULT  = 3'd5,
    SKIP    = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [87:0]          r_hdr;
  logic [3:0]           r_cnt;
  logic [pADRESS-1:0]   r_src_port;
  logic [pADRESS-1:0]   r_port_num;
  logic [pADRESS-1:0]   r_fwd_port;
  logic [pHASH-1:0]     r_mac_sa;
  logic [pHASH-1:0]     r_mac_da;
  logic                 r_fwd_flood;
  logic                 r_da_grp;
  logic                 r_sa_grp;
  logic                 r_eof_seen;
  logic [7:0]           r_runt_cnt;
  logic [95:0]          w_hdr_next;
  logic                 w_start;
  logic                 w_shift;
  logic                 w_hdr_done;
  logic                 w_runt;

  // Fold the 48-bit address into pHASH-bit chunks, last chunk zero-padded.
  function automatic logic [pHASH-1:0] f_hash(input logic [47:0] a);
    logic [pHASH-1:0] h;
    logic [47:0]      sh;
    h = '0;
    for (int c = 0; c < 48; c += pHASH) begin
      sh = a >> c;
      h  = h ^ sh[pHASH-1:0];
    end
    return h;
  endfunction

  assign w_hdr_next = {r_hdr, i_data};

  always_ff @(posedge iclk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_start        = 1'b0;
    w_shift        = 1'b0;
    w_hdr_done     = 1'b0;
    w_runt         = 1'b0;
    o_write_enable = 1'b0;
    o_fwd_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_valid && i_sof) begin
          if (i_eof) w_runt = 1'b1;
          else begin
            w_start = 1'b1;
            w_next  = HDR;
          end
        end
      end
      HDR: begin
        if (i_valid) begin
          if (i_sof) begin
            if (i_eof) begin
              w_runt = 1'b1;
              w_next = IDLE;
            end else begin
              w_start = 1'b1;
            end
          end else if (r_cnt == 4'd11) begin
            w_hdr_done = 1'b1;
            w_next     = LOOKUP;
          end else if (i_eof) begin
            w_runt = 1'b1;
            w_next = IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      LOOKUP:  w_next = CAPTURE;
      CAPTURE: w_next = LEARN;
      LEARN: begin
        o_write_enable = ~r_sa_grp;
        w_next         = RESULT;
      end
      RESULT: begin
        o_fwd_valid = 1'b1;
        if (i_fwd_ready)
          w_next = (r_eof_seen || (i_valid && i_eof)) ? IDLE : SKIP;
      end
      SKIP: begin
        if (i_valid) begin
          if (i_sof) begin
            if (i_eof) begin
              w_runt = 1'b1;
              w_next = IDLE;
            end else begin
              w_start = 1'b1;
              w_next  = HDR;
            end
          end else if (i_eof) begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (i_rst) begin
      r_hdr       <= '0;
      r_cnt       <= '0;
      r_src_port  <= '0;
      r_port_num  <= '0;
      r_fwd_port  <= '0;
      r_mac_sa    <= '0;
      r_mac_da    <= '0;
      r_fwd_flood <= 1'b0;
      r_da_grp    <= 1'b0;
      r_sa_grp    <= 1'b0;
      r_eof_seen  <= 1'b0;
      r_runt_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_hdr      <= {80'b0, i_data};
        r_cnt      <= 4'd1;
        r_src_port <= i_src_port;
      end else if (w_shift) begin
        r_hdr <= w_hdr_next[87:0];
        r_cnt <= r_cnt + 4'd1;
      end
      // Header complete: everything downstream works from these snapshots,
      // so the next frame may overwrite r_hdr freely.
      if (w_hdr_done) begin
        r_cnt      <= r_cnt + 4'd1;
        r_mac_da   <= f_hash(w_hdr_next[95:48]);
        r_mac_sa   <= f_hash(w_hdr_next[47:0]);
        r_da_grp   <= w_hdr_next[88];
        r_sa_grp   <= w_hdr_next[40];
        r_port_num <= r_src_port;
        r_eof_seen <= i_eof;
      end
      if ((r_state == LOOKUP || r_state == CAPTURE || r_state == LEARN ||
           r_state == RESULT) && i_valid && i_eof)
        r_eof_seen <= 1'b1;
      if (r_state == CAPTURE) begin
        r_fwd_port  <= i_table_port;
        r_fwd_flood <= r_da_grp;
      end
      if (w_runt && (r_runt_cnt != 8'hFF))
        r_runt_cnt <= r_runt_cnt + 8'd1;
    end
  end

  assign o_port_num  = r_port_num;
  assign o_MAC_SA    = r_mac_sa;
  assign o_MAC_DA    = r_mac_da;
  assign o_fwd_port  = r_fwd_port;
  assign o_fwd_flood = r_fwd_flood;
  assign o_runt_cnt  = r_runt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_header_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_header_parser
// Description : Directed table-driven bench for mac_header_parser.
// Revision    : 1.0
// ============================================================================
module tb_mac_header_parser;

  logic        iclk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_sof;
  logic        i_eof;
  logic [1:0]  i_src_port;
  logic [1:0]  i_table_port;
  logic        o_write_enable;
  logic [1:0]  o_port_num;
  logic [13:0] o_MAC_SA;
  logic [13:0] o_MAC_DA;
  logic        o_fwd_valid;
  logic        i_fwd_ready;
  logic [1:0]  o_fwd_port;
  logic        o_fwd_flood;
  logic [7:0]  o_runt_cnt;

  mac_header_parser #(.pADRESS(2), .pHASH(14)) dut (
    .iclk           (iclk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_sof          (i_sof),
    .i_eof          (i_eof),
    .i_src_port     (i_src_port),
    .i_table_port   (i_table_port),
    .o_write_enable (o_write_enable),
    .o_port_num     (o_port_num),
    .o_MAC_SA       (o_MAC_SA),
    .o_MAC_DA       (o_MAC_DA),
    .o_fwd_valid    (o_fwd_valid),
    .i_fwd_ready    (i_fwd_ready),
    .o_fwd_port     (o_fwd_port),
    .o_fwd_flood    (o_fwd_flood),
    .o_runt_cnt     (o_runt_cnt)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [47:0] da;
    logic [47:0] sa;
    int          len;
    logic [1:0]  src;
    logic [1:0]  tport;
    int          learn;
    int          fwd;
    int          flood;
    int          runt;
  } vec_t;

  vec_t vt[8];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_last = 0;

  // Table responder: returns the programmed port only for the expected key.
  logic [13:0] tbl_key  = '0;
  logic [1:0]  tbl_port = '0;
  assign i_table_port = (o_MAC_DA == tbl_key) ? tbl_port : ~tbl_port;

  int          we_tot = 0, fv_tot = 0, unstable_tot = 0;
  int          we_cyc = 0, fv_cyc = 0;
  logic [13:0] we_sa  = '0;
  logic [1:0]  we_port = '0, fv_port = '0, prev_port = '0;
  logic        fv_flood = 1'b0, prev_fv = 1'b0, prev_flood = 1'b0;

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (o_write_enable) begin
      we_tot++;
      we_sa   = o_MAC_SA;
      we_port = o_port_num;
      we_cyc  = cyc;
    end
    if (o_fwd_valid) begin
      fv_tot++;
      fv_port  = o_fwd_port;
      fv_flood = o_fwd_flood;
      fv_cyc   = cyc;
      if (prev_fv && (o_fwd_port != prev_port || o_fwd_flood != prev_flood))
        unstable_tot++;
    end
    prev_fv    = o_fwd_valid;
    prev_port  = o_fwd_port;
    prev_flood = o_fwd_flood;
  end

  function automatic logic [13:0] f_hash(input logic [47:0] a);
    return a[13:0] ^ a[27:14] ^ a[41:28] ^ {8'b0, a[47:42]};
  endfunction

  function automatic logic [7:0] frame_byte(input vec_t v, input int i);
    if (i < 6)  return v.da[47-8*i -: 8];
    if (i < 12) return v.sa[47-8*(i-6) -: 8];
    return 8'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
    i_valid = 1'b1;
    i_data  = d;
    i_sof   = s;
    i_eof   = e;
    @(posedge iclk); #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_eof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iclk); #1;
    end
  endtask

  task automatic send_bytes(input vec_t v);
    i_src_port = v.src;
    tbl_key    = f_hash(v.da);
    tbl_port   = v.tport;
    for (int i = 0; i < v.len; i++) begin
      if (i == 11) n_last = cyc;
      drive_byte(frame_byte(v, i), i == 0, i == v.len - 1);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int we0, input int fv0,
                           input int r0);
    chk({tag, "_learn_cnt"}, 64'(we_tot - we0), 64'(v.learn));
    chk({tag, "_fwd_cnt"},   64'(fv_tot - fv0), 64'(v.fwd));
    chk({tag, "_runt_delta"}, 64'(int'(o_runt_cnt) - r0), 64'(v.runt));
    if (v.learn != 0) begin
      chk({tag, "_learn_sa"},   64'(we_sa), 64'(f_hash(v.sa)));
      chk({tag, "_learn_port"}, 64'(we_port), 64'(v.src));
      chk({tag, "_learn_lat"},  64'(we_cyc - n_last), 64'd3);
    end
    if (v.fwd != 0) begin
      chk({tag, "_fwd_port"},  64'(fv_port), 64'(v.tport));
      chk({tag, "_fwd_flood"}, 64'(fv_flood), 64'(v.flood));
      chk({tag, "_fwd_lat"},   64'(fv_cyc - n_last), 64'd4);
      chk({tag, "_mac_da"},    64'(o_MAC_DA), 64'(f_hash(v.da)));
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int we0, fv0, r0;
    we0 = we_tot; fv0 = fv_tot; r0 = int'(o_runt_cnt);
    send_bytes(v);
    idle(8);
    check_vec(tag, v, we0, fv0, r0);
  endtask

  task automatic wait_fv(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge iclk);
      if (o_fwd_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    vec_t vb;
    bit   found;
    int   we0, fv0, us0, r0;

    //        DA               SA               len src tp  lrn fwd fld runt
    vt[0] = '{48'h001122334455, 48'h00AABBCCDDEE, 64, 2'd2, 2'd1, 1, 1, 0, 0};
    vt[1] = '{48'hFFFFFFFFFFFF, 48'h020000000001, 20, 2'd1, 2'd3, 1, 1, 1, 0};
    vt[2] = '{48'h0A0B0C0D0E0F, 48'h010203040506, 12, 2'd3, 2'd2, 0, 1, 0, 0};
    vt[3] = '{48'h0100005E0001, 48'h001B21000002, 16, 2'd0, 2'd2, 1, 1, 1, 0};
    vt[4] = '{48'h001122334455, 48'h00AABBCCDDEE,  8, 2'd1, 2'd1, 0, 0, 0, 1};
    vt[5] = '{48'h001122334455, 48'h00AABBCCDDEE, 11, 2'd1, 2'd1, 0, 0, 0, 1};
    vt[6] = '{48'h001122334455, 48'h00AABBCCDDEE,  1, 2'd1, 2'd1, 0, 0, 0, 1};
    vt[7] = '{48'h00000000ABCD, 48'h001234567890, 13, 2'd1, 2'd0, 1, 1, 0, 0};

    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_sof = 1'b0; i_eof = 1'b0;
    i_src_port = '0; i_fwd_ready = 1'b1;
    repeat (3) @(posedge iclk);
    #1 i_rst = 1'b0;
    @(negedge iclk);
    chk("rst_we",    64'(o_write_enable), 64'd0);
    chk("rst_fv",    64'(o_fwd_valid), 64'd0);
    chk("rst_flood", 64'(o_fwd_flood), 64'd0);
    chk("rst_fport", 64'(o_fwd_port), 64'd0);
    chk("rst_pnum",  64'(o_port_num), 64'd0);
    chk("rst_sa",    64'(o_MAC_SA), 64'd0);
    chk("rst_da",    64'(o_MAC_DA), 64'd0);
    chk("rst_runt",  64'(o_runt_cnt), 64'd0);
    @(posedge iclk); #1;

    for (int k = 0; k < 8; k++) run_vec($sformatf("v%0d", k), vt[k]);

    // Backpressure: ready low for 5 cycles of o_fwd_valid.
    we0 = we_tot; fv0 = fv_tot; us0 = unstable_tot;
    i_fwd_ready = 1'b0;
    fork
      send_bytes(vt[0]);
      begin
        wait_fv(found);
        chk("bp_fv_seen", 64'(found), 64'd1);
        repeat (5) @(posedge iclk);
        #1 i_fwd_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_fv_cycles", 64'(fv_tot - fv0), 64'd6);
    chk("bp_stable",    64'(unstable_tot - us0), 64'd0);
    chk("bp_fwd_port",  64'(fv_port), 64'(vt[0].tport));
    chk("bp_learn_cnt", 64'(we_tot - we0), 64'd1);
    run_vec("bp_next", vt[3]);

    // 12-byte frame ending on byte 12, next SOF right after acceptance.
    vb = '{48'h0000000000AA, 48'h00000000BBCC, 14, 2'd1, 2'd2, 1, 1, 0, 0};
    send_bytes(vt[2]);
    wait_fv(found);
    chk("b2b_fv_seen", 64'(found), 64'd1);
    @(posedge iclk); #1;
    we0 = we_tot; fv0 = fv_tot; r0 = int'(o_runt_cnt);
    send_bytes(vb);
    idle(8);
    check_vec("b2b", vb, we0, fv0, r0);

    // Runt counter saturation.
    for (int k = 0; k < 300; k++) begin
      drive_byte(8'h01, 1'b1, 1'b0);
      drive_byte(8'h02, 1'b0, 1'b1);
    end
    idle(2);
    chk("runt_sat", 64'(o_runt_cnt), 64'd255);

    // Reset mid-frame at byte 9.
    i_src_port = 2'd3;
    for (int i = 0; i < 9; i++) drive_byte(frame_byte(vt[0], i), i == 0, 1'b0);
    i_rst = 1'b1;
    drive_byte(frame_byte(vt[0], 9), 1'b0, 1'b0);
    i_rst = 1'b0;
    @(negedge iclk);
    chk("mrst_da",    64'(o_MAC_DA), 64'd0);
    chk("mrst_sa",    64'(o_MAC_SA), 64'd0);
    chk("mrst_pnum",  64'(o_port_num), 64'd0);
    chk("mrst_fport", 64'(o_fwd_port), 64'd0);
    chk("mrst_flood", 64'(o_fwd_flood), 64'd0);
    chk("mrst_runt",  64'(o_runt_cnt), 64'd0);
    @(posedge iclk); #1;
    we0 = we_tot; fv0 = fv_tot;
    for (int i = 10; i < 16; i++) drive_byte(frame_byte(vt[0], i), 1'b0, i == 15);
    idle(10);
    chk("mrst_no_learn", 64'(we_tot - we0), 64'd0);
    chk("mrst_no_fwd",   64'(fv_tot - fv0), 64'd0);
    chk("mrst_no_runt",  64'(o_runt_cnt), 64'd0);
    run_vec("post_rst", vt[7]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_header_parser.md
MAC_HEADER_PARSER -- requirements
Module: mac_header_parser

Interface
REQ-001 The block SHALL have parameter pADRESS, default 2: width of a port number.
REQ-002 The block SHALL have parameter pHASH, default 14: width of a hashed MAC address.
REQ-003 iclk  input  1  the single clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  i_data/i_sof/i_eof qualify this cycle.
REQ-006 i_data  input  8  frame byte; first byte of frame is DA[47:40].
REQ-007 i_sof  input  1  first byte of frame (valid only with i_valid).
REQ-008 i_eof  input  1  last byte of frame (valid only with i_valid).
REQ-009 i_src_port  input  pADRESS  ingress port of the current frame, sampled on the SOF beat.
REQ-010 i_table_port  input  pADRESS  MAC table lookup result, one cycle after o_MAC_DA is presented.
REQ-011 o_write_enable  output  1  one-cycle learn strobe to the MAC table.
REQ-012 o_port_num  output  pADRESS  port to learn against o_MAC_SA.
REQ-013 o_MAC_SA  output  pHASH  hashed source address.
REQ-014 o_MAC_DA  output  pHASH  hashed destination address (lookup index).
REQ-015 o_fwd_valid  output  1  forwarding decision available.
REQ-016 i_fwd_ready  input  1  downstream accepts the decision.
REQ-017 o_fwd_port  output  pADRESS  egress port from the table.
REQ-018 o_fwd_flood  output  1  DA is group/broadcast; flood, ignore o_fwd_port.
REQ-019 o_runt_cnt  output  8  saturating count of frames ending before byte 12.

Function
REQ-020 States SHALL be IDLE, HDR, LOOKUP, CAPTURE, LEARN, RESULT, SKIP.
REQ-021 IDLE: beat with i_valid&i_sof SHALL store byte as DA[47:40], latch i_src_port, set byte count 1, go HDR; non-SOF beats ignored.
REQ-022 HDR: each i_valid beat SHALL shift into the 96-bit header (bytes 0-5 DA, 6-11 SA, MSB first) and increment count.
REQ-023 HDR: i_sof SHALL restart capture as in REQ-021 without counting a runt.
REQ-024 HDR: i_eof on a beat with count < 11 before the beat SHALL increment o_runt_cnt (saturate at 255) and go IDLE; no lookup, learn or result.
REQ-025 On byte 12 accepted, the block SHALL go LOOKUP; if that beat has i_eof, record eof_seen=1, else eof_seen=0.
REQ-026 Hash SHALL be h = A[13:0] ^ A[27:14] ^ A[41:28] ^ {8'b0, A[47:42]} for pHASH=14, computed for both DA and SA.
REQ-027 LOOKUP: o_MAC_DA SHALL hold hash(DA) from this cycle until the next frame's LOOKUP; next state CAPTURE.
REQ-028 CAPTURE: the block SHALL latch i_table_port into o_fwd_port; o_fwd_flood SHALL equal DA[40] (group bit); go LEARN.
REQ-029 LEARN: o_write_enable SHALL be 1 for exactly this cycle with o_MAC_SA=hash(SA), o_port_num=latched source port, unless SA[40]=1 (group SA: no learn); go RESULT.
REQ-030 Learn SHALL occur after lookup so a frame with SA==DA forwards to the previously stored port.
REQ-031 RESULT: o_fwd_valid SHALL be 1 and o_fwd_port/o_fwd_flood stable until i_fwd_ready=1; on acceptance go IDLE if eof_seen else SKIP.
REQ-032 In LOOKUP..RESULT, input beats SHALL be discarded; an i_eof beat SHALL set eof_seen.
REQ-033 SKIP: beats SHALL be discarded until i_eof, then IDLE; i_sof in SKIP SHALL start a new frame as in REQ-021.
REQ-034 i_sof and i_eof on one beat in IDLE SHALL count a runt and stay IDLE.
REQ-035 Latency: last SA byte at cycle n -> o_write_enable at n+3, o_fwd_valid at n+4.

Reset
REQ-036 i_rst=1 SHALL, on the next edge, force IDLE and o_write_enable=0, o_fwd_valid=0, o_fwd_flood=0, o_fwd_port=0, o_port_num=0, o_MAC_SA=0, o_MAC_DA=0, o_runt_cnt=0, eof_seen=0, byte count 0.
REQ-037 Reset mid-frame SHALL abandon the frame with no learn strobe and no runt count; later bytes are ignored until the next i_sof.

Verification
REQ-038 Port 2, DA 00:11:22:33:44:55, SA 00:AA:BB:CC:DD:EE, 64 bytes, i_table_port=1, ready=1 -> one learn with o_MAC_SA=hash(SA), o_port_num=2; o_fwd_valid 1 cycle, o_fwd_port=1, flood=0.
REQ-039 DA FF:FF:FF:FF:FF:FF -> o_fwd_flood=1; learn still issued.
REQ-040 8-byte frame -> o_runt_cnt 0->1, no o_write_enable, no o_fwd_valid; 300 runts -> o_runt_cnt=255.
REQ-041 i_fwd_ready low 5 cycles -> o_fwd_valid held 6 cycles, outputs stable; frame bytes meanwhile dropped; next SOF after eof parsed.
REQ-042 12-byte frame with eof on byte 12, next SOF immediately after RESULT accept -> returns via IDLE, second frame parsed correctly.
REQ-043 i_rst at byte 9 -> outputs zero next cycle, no learn, runt count unchanged.
